// File: rtl/dwt_pkg.sv
// Shared constants and arithmetic helpers for the single-level DWT analysis stage.
// Default coefficients are the db2 analysis pair scaled to 9-bit signed values.
package dwt_pkg;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] value;
    } sat_res_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int default_coef(input logic hi_bank, input int k);
        int c;
        case (k)
            0:       c = hi_bank ? -124 : -34;
            1:       c = hi_bank ?  214 :  57;
            2:       c = hi_bank ?  -58 : 214;
            3:       c = hi_bank ?  -34 : 123;
            default: c = 0;
        endcase
        return c;
    endfunction

    // Round half-up by dropping shift LSBs, then clamp into a w_out-bit signed range.
    function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                           input int shift, input int w_out);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_res_t           res;
        r = acc;
        if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        res.ovf   = 1'b0;
        res.value = r;
        if (w_out < 64) begin
            max_v = (64'sd1 <<< (w_out - 1)) - 64'sd1;
            min_v = -max_v - 64'sd1;
            if (r > max_v) begin
                res.value = max_v;
                res.ovf   = 1'b1;
            end else if (r < min_v) begin
                res.value = min_v;
                res.ovf   = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dwt_fir_mac.sv
// One FIR branch of the DWT stage: registered products, registered adder tree,
// registered round/saturate. The tap line and coefficients are owned by the parent.
module dwt_fir_mac
    import dwt_pkg::*;
#(
    parameter int W_IN   = 9,
    parameter int C_W    = 9,
    parameter int N_TAPS = 4,
    parameter int W_OUT  = 25,
    parameter int SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    prod_en,
    input  logic                    sum_en,
    input  logic                    out_en,
    input  logic signed [W_IN-1:0]  taps [N_TAPS],
    input  logic signed [C_W-1:0]   coef [N_TAPS],
    output logic signed [W_OUT-1:0] y,
    output logic                    ovf
);

    localparam int P_W   = W_IN + C_W;
    localparam int ACC_W = P_W + clog2(N_TAPS);

    logic signed [P_W-1:0]   prod_q [N_TAPS];
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [W_OUT-1:0] y_q;
    sat_res_t                sr;

    always_comb begin
        // NOTE: acc_d gets a value before the loop so no path leaves it unassigned (no latch).
        acc_d = '0;
        for (int k = 0; k < N_TAPS; k++) acc_d = acc_d + ACC_W'(prod_q[k]);
    end

    assign sr = sat_round(64'(acc_q), SHIFT, W_OUT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            if (prod_en) begin
                for (int k = 0; k < N_TAPS; k++) prod_q[k] <= P_W'(taps[k]) * P_W'(coef[k]);
            end
            if (sum_en) acc_q <= acc_d;
            if (out_en) y_q <= W_OUT'(sr.value);
        end
    end

    assign y   = y_q;
    assign ovf = sr.ovf;

endmodule

// File: rtl/dwt_analysis_stage.sv
// Single-level DWT analysis stage: shared tap line feeding a low/high FIR pair,
// decimated by 2, with run-time loadable coefficient banks and sticky saturation flag.
module dwt_analysis_stage
    import dwt_pkg::*;
#(
    parameter int W_IN   = 9,
    parameter int C_W    = 9,
    parameter int N_TAPS = 4,
    parameter int W_OUT  = 25,
    parameter int SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [W_IN-1:0]  in_data,
    input  logic                    coef_we,
    input  logic                    coef_sel,
    input  logic [3:0]              coef_addr,
    input  logic signed [C_W-1:0]   coef_wdata,
    output logic signed [W_OUT-1:0] lo_data,
    output logic signed [W_OUT-1:0] hi_data,
    output logic                    out_valid,
    output logic                    sat_flag
);

    logic                  phase_q;
    logic signed [W_IN-1:0] taps_q [N_TAPS];
    logic signed [C_W-1:0]  lo_coef_q [N_TAPS];
    logic signed [C_W-1:0]  hi_coef_q [N_TAPS];
    logic                  wr_pend_q, wr_sel_q;
    logic [3:0]            wr_addr_q;
    logic signed [C_W-1:0]  wr_data_q;
    logic                  v1_q, v2_q, v3_q, out_valid_q;
    logic                  sat_flag_q, sat_flag_d;
    logic                  issue, lo_ovf, hi_ovf;

    assign issue      = in_valid && phase_q && !clr;
    assign sat_flag_d = sat_flag_q | (v3_q & (lo_ovf | hi_ovf));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N_TAPS; k++) taps_q[k] <= '0;
            phase_q     <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < N_TAPS; k++) taps_q[k] <= '0;
            phase_q     <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking shifts read every old tap value, so the line moves one step per sample.
            if (in_valid) begin
                taps_q[0] <= in_data;
                for (int k = 1; k < N_TAPS; k++) taps_q[k] <= taps_q[k-1];
                phase_q <= !phase_q;
            end
            v1_q        <= issue;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            out_valid_q <= v3_q;
            sat_flag_q  <= sat_flag_d;
        end
    end

    // Writes commit one edge late so the products of an issue on the write edge see the old value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: coefficient banks are real state with defined defaults, so they are reset, not left X.
            for (int k = 0; k < N_TAPS; k++) begin
                lo_coef_q[k] <= C_W'(default_coef(1'b0, k));
                hi_coef_q[k] <= C_W'(default_coef(1'b1, k));
            end
            wr_pend_q <= 1'b0;
            wr_sel_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_pend_q <= coef_we && (int'(coef_addr) < N_TAPS);
            wr_sel_q  <= coef_sel;
            wr_addr_q <= coef_addr;
            wr_data_q <= coef_wdata;
            if (wr_pend_q) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    if (wr_addr_q == 4'(k)) begin
                        if (wr_sel_q) hi_coef_q[k] <= wr_data_q;
                        else          lo_coef_q[k] <= wr_data_q;
                    end
                end
            end
        end
    end

    dwt_fir_mac #(
        .W_IN(W_IN), .C_W(C_W), .N_TAPS(N_TAPS), .W_OUT(W_OUT), .SHIFT(SHIFT)
    ) u_lo (
        .clk(clk), .rstn(rstn),
        .prod_en(v1_q && !clr), .sum_en(v2_q && !clr), .out_en(v3_q && !clr),
        .taps(taps_q), .coef(lo_coef_q), .y(lo_data), .ovf(lo_ovf)
    );

    dwt_fir_mac #(
        .W_IN(W_IN), .C_W(C_W), .N_TAPS(N_TAPS), .W_OUT(W_OUT), .SHIFT(SHIFT)
    ) u_hi (
        .clk(clk), .rstn(rstn),
        .prod_en(v1_q && !clr), .sum_en(v2_q && !clr), .out_en(v3_q && !clr),
        .taps(taps_q), .coef(hi_coef_q), .y(hi_data), .ovf(hi_ovf)
    );

    assign out_valid = out_valid_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_dwt_analysis_stage.sv
// Self-checking bench: three stage configurations share one stimulus stream and are
// compared every cycle against an issue-queue reference model.
module tb_dwt_analysis_stage;

    localparam int CFG_W [3] = '{25, 16, 25};
    localparam int CFG_S [3] = '{0, 0, 8};

    logic clk = 1'b0;
    logic rstn, clr, in_valid, coef_we, coef_sel;
    logic signed [8:0] in_data, coef_wdata;
    logic [3:0] coef_addr;
    logic signed [24:0] lo0, hi0, lo2, hi2;
    logic signed [15:0] lo1, hi1;
    logic ov0, ov1, ov2, sat0, sat1, sat2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    dwt_analysis_stage #(.W_IN(9), .C_W(9), .N_TAPS(4), .W_OUT(25), .SHIFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_sel(coef_sel), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .lo_data(lo0), .hi_data(hi0), .out_valid(ov0), .sat_flag(sat0));
    dwt_analysis_stage #(.W_IN(9), .C_W(9), .N_TAPS(4), .W_OUT(16), .SHIFT(0)) dut1 (
        .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_sel(coef_sel), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .lo_data(lo1), .hi_data(hi1), .out_valid(ov1), .sat_flag(sat1));
    dwt_analysis_stage #(.W_IN(9), .C_W(9), .N_TAPS(4), .W_OUT(25), .SHIFT(8)) dut2 (
        .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_sel(coef_sel), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .lo_data(lo2), .hi_data(hi2), .out_valid(ov2), .sat_flag(sat2));

    // ---------------- reference model ----------------
    typedef struct {
        longint due;
        longint acc_lo;
        longint acc_hi;
    } iss_t;

    iss_t   pend [$];
    iss_t   m_it;
    longint hist [4];
    longint lo_bank [4];
    longint hi_bank [4];
    longint cyc = 0;
    bit     phase;
    bit     exp_valid;
    longint exp_lo [3];
    longint exp_hi [3];
    bit     exp_sat [3];
    bit     o_lo, o_hi;

    // floor((acc + 2^(sh-1)) / 2^sh)
    function automatic longint rnd(input longint acc, input int sh);
        longint d, n, q;
        if (sh == 0) return acc;
        d = longint'(1) << sh;
        n = acc + d / 2;
        q = n / d;
        if (n < 0 && q * d != n) q = q - 1;
        return q;
    endfunction

    function automatic longint shape(input longint acc, input int c, output bit o);
        longint r, lim;
        r   = rnd(acc, CFG_S[c]);
        lim = longint'(1) << (CFG_W[c] - 1);
        o   = 1'b0;
        if (r >= lim) begin
            o = 1'b1;
            return lim - 1;
        end
        if (r < -lim) begin
            o = 1'b1;
            return -lim;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend.delete();
            phase     = 1'b0;
            exp_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                exp_lo[c] = 0; exp_hi[c] = 0; exp_sat[c] = 1'b0;
            end
            for (int k = 0; k < 4; k++) hist[k] = 0;
            lo_bank = '{-34, 57, 214, 123};
            hi_bank = '{-124, 214, -58, -34};
        end else begin
            cyc++;
            exp_valid = 1'b0;
            if (clr) begin
                pend.delete();
                phase = 1'b0;
                for (int k = 0; k < 4; k++) hist[k] = 0;
                for (int c = 0; c < 3; c++) exp_sat[c] = 1'b0;
            end else begin
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    m_it = pend.pop_front();
                    exp_valid = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        exp_lo[c] = shape(m_it.acc_lo, c, o_lo);
                        exp_hi[c] = shape(m_it.acc_hi, c, o_hi);
                        exp_sat[c] = exp_sat[c] | o_lo | o_hi;
                    end
                end
                if (in_valid) begin
                    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
                    hist[0] = longint'(in_data);
                    if (phase) begin
                        m_it.due = cyc + 3;
                        m_it.acc_lo = 0;
                        m_it.acc_hi = 0;
                        for (int k = 0; k < 4; k++) begin
                            m_it.acc_lo += lo_bank[k] * hist[k];
                            m_it.acc_hi += hi_bank[k] * hist[k];
                        end
                        pend.push_back(m_it);
                    end
                    phase = !phase;
                end
            end
            if (coef_we && coef_addr < 4'd4) begin
                if (coef_sel) hi_bank[coef_addr] = longint'(coef_wdata);
                else          lo_bank[coef_addr] = longint'(coef_wdata);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input int c, input longint lo, input longint hi,
                       input logic ov, input logic sat);
        check($sformatf("%s_valid", tag), longint'(ov), longint'(exp_valid));
        check($sformatf("%s_lo", tag), lo, exp_lo[c]);
        check($sformatf("%s_hi", tag), hi, exp_hi[c]);
        check($sformatf("%s_sat", tag), longint'(sat), longint'(exp_sat[c]));
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            cmp("d0", 0, lo0, hi0, ov0, sat0);
            cmp("d1", 1, lo1, hi1, ov1, sat1);
            cmp("d2", 2, lo2, hi2, ov2, sat2);
            if (ov0 === 1'b1) n_pulses++;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_lo0"}, lo0, 0);  check({tag, "_hi0"}, hi0, 0);
        check({tag, "_lo1"}, lo1, 0);  check({tag, "_hi1"}, hi1, 0);
        check({tag, "_lo2"}, lo2, 0);  check({tag, "_hi2"}, hi2, 0);
        check({tag, "_ov"}, longint'(ov0 | ov1 | ov2), 0);
        check({tag, "_sat"}, longint'(sat0 | sat1 | sat2), 0);
    endtask

    // ---------------- stimulus ----------------
    task automatic send(input int d);
        in_valid = 1'b1;
        in_data  = 9'(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ov0 !== 1'b1 && n < 16);
        if (ov0 !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: out_valid got 0 within 16 cycles, required 1", name);
        end
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base_p;

    initial begin
        rstn = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_sel = 1'b0; coef_addr = '0; coef_wdata = '0;
        #1 rstn = 1'b0;
        idle(2);
        check_zero("reset");
        #2 rstn = 1'b1;
        @(negedge clk);

        // impulse response with default coefficients
        send(1); send(0); send(0); send(0);
        wait_valid("imp_a");
        check("imp_a_lo", lo0, 57);   check("imp_a_hi", hi0, 214);
        check("imp_a_lo_s8", lo2, 0); check("imp_a_hi_s8", hi2, 1);
        check("imp_a_model", exp_lo[0], 57);
        wait_valid("imp_b");
        check("imp_b_lo", lo0, 123);  check("imp_b_hi", hi0, -34);
        send(128); send(0); send(0); send(0);
        wait_valid("imp128");
        check("imp128_lo_s8", lo2, 29); check("imp128_lo", lo0, 7296);
        idle(4);

        // saturation on the 16-bit output
        repeat (8) send(-256);
        wait_valid("sat");
        check("sat_lo16", lo1, -32768); check("sat_hi16", hi1, 512);
        check("sat_lo25", lo0, -92160); check("sat_flag16", longint'(sat1), 1);
        check("sat_flag25", longint'(sat0), 0);
        idle(2);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("clr_sat16", longint'(sat1), 0);

        // coefficient write on the issuing edge, then an out-of-range address
        send(1);
        coef_we = 1'b1; coef_sel = 1'b0; coef_addr = 4'd1; coef_wdata = 9'sd100;
        send(0);
        coef_we = 1'b0;
        wait_valid("cw_old");
        check("cw_old_lo", lo0, 57);
        coef_we = 1'b1; coef_addr = 4'd5; coef_wdata = 9'sd77;
        send(1);
        coef_we = 1'b0;
        send(0);
        wait_valid("cw_new");
        check("cw_new_lo", lo0, 223);
        idle(4);

        // random samples with random gaps and occasional coefficient writes, then gapless
        base_p = n_pulses;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                coef_we    = 1'b1;
                coef_sel   = 1'($urandom_range(0, 1));
                coef_addr  = 4'($urandom_range(0, 7));
                coef_wdata = 9'(rnd_sample());
            end
            send(rnd_sample());
            coef_we = 1'b0;
            idle(int'($urandom_range(0, 5)));
        end
        for (int i = 0; i < 20; i++) send(rnd_sample());
        idle(8);
        check("rand_pulses", n_pulses - base_p, 30);

        // clr one cycle after an issue, with a dropped simultaneous sample
        base_p = n_pulses;
        send(rnd_sample()); send(rnd_sample());
        clr = 1'b1; in_valid = 1'b1; in_data = 9'sd5;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        idle(6);
        check("clr_discard", n_pulses - base_p, 0);
        send(1);
        idle(5);
        check("clr_one_sample", n_pulses - base_p, 0);
        send(0);
        wait_valid("clr_fresh");
        idle(1);
        check("clr_fresh_pulses", n_pulses - base_p, 1);
        idle(3);

        // asynchronous reset mid-stream restores default coefficients
        repeat (5) send(rnd_sample());
        #2 rstn = 1'b0;
        #1 check_zero("mid_rst");
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        send(1); send(0); send(0); send(0);
        wait_valid("post_rst");
        check("post_rst_lo", lo0, 57);   check("post_rst_hi", hi0, 214);
        check("post_rst_lo_s8", lo2, 0); check("post_rst_hi_s8", hi2, 1);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
